acc_wb: RTL and testbench
=========================

Name: acc_wb

Overview:
- Downstream stage of the convolution accumulator. Captures each finished 16-bit accumulated sum when the accumulator flags it, with optional ReLU.
- Buffers sums in a small FIFO and writes them to the output feature-map memory at linear addresses.
- Emits a one-cycle plane_rdy pulse after the last pixel of each plane is written. The accumulator uses this pulse to advance its per-plane bias.

Parameters:
- PLANE_PIX, 24, output pixels per plane
- NUM_PLANES, 6, planes per frame
- ADDR_W, 8, write address width; must satisfy 2^ADDR_W >= NUM_PLANES*PLANE_PIX
- FIFO_DEPTH, 4, sum buffer entries; power of two, >= 2

Ports:
- clk  input  1  clock, rising edge
- rst  input  1  reset, asynchronous, active-high
- start  input  1  one-cycle pulse: begin a new frame
- sum  input  16  accumulated sum from the accumulator (two's complement)
- sum_valid  input  1  one-cycle strobe: sum holds a finished pixel
- wr_en  output  1  memory write request
- wr_addr  output  ADDR_W  linear address = plane*PLANE_PIX + pix
- wr_data  output  16  value to write
- wr_ready  input  1  memory accepts the write this cycle
- plane_rdy  output  1  one-cycle pulse: plane fully written
- done  output  1  level: all NUM_PLANES planes written
- busy  output  1  high in RUN
- overflow  output  1  sticky: a sum_valid was dropped

Behaviour:
- Reset (async, rst=1): state=IDLE; FIFO empty; pix=0; plane=0; wr_en=0; wr_addr=0; wr_data=0; plane_rdy=0; done=0; busy=0; overflow=0.
- States:
  - IDLE: sum_valid ignored. start -> RUN.
  - RUN: busy=1. Last write of last plane accepted -> DONE.
  - DONE: done=1. sum_valid ignored, overflow not set. start -> RUN.
- start in any state:
  - flushes the FIFO; pix=0, plane=0; clears done and overflow; enters RUN next cycle.
  - sum_valid in the same cycle as start is dropped.
- Push (RUN only): sum_valid=1 and (count<FIFO_DEPTH, or a pop occurs in the same cycle). Otherwise the sum is dropped and overflow<=1.
- Pop: wr_en && wr_ready. Simultaneous push and pop leaves count unchanged.
- Write port:
  - wr_en is registered and high whenever the FIFO is non-empty in RUN.
  - Latency: sum_valid in cycle N into an empty FIFO -> wr_en=1 in cycle N+1 with that data.
  - wr_data and wr_addr stay stable while wr_en=1 and wr_ready=0.
  - FIFO order preserved.
- Addressing on each accepted write:
  - pix increments; at pix=PLANE_PIX-1 it wraps to 0 and plane increments.
  - wr_addr = plane*PLANE_PIX + pix. Compute it with a running base register (add PLANE_PIX on wrap), not a multiplier.
- plane_rdy: registered pulse, high exactly one cycle after the write with pix=PLANE_PIX-1 is accepted, for every plane including the last.
- done asserts the same cycle as the final plane_rdy.
- Arithmetic: data is stored 16-bit unmodified except for ReLU (see Optional Feature). No widening, no saturation.
- Reset mid-frame: everything returns to reset values immediately; in-flight FIFO contents are lost.

Optional Feature:
- Macro: ACC_WB_RELU_EN.
- Defined: ReLU applied at push; if sum[15]=1, the stored value is 16'h0000, else sum.
- Undefined: sum stored unchanged, negatives pass through.
- Either way, the address, handshake and timing behaviour is identical.

Test Plan:
- Basic: rst, start, then 24 sum_valid pulses of 16'h0003 with wr_ready=1. Expect:
  - wr_addr 0..23 each one cycle after its sum_valid;
  - wr_data=16'h0003;
  - plane_rdy one pulse, the cycle after addr 23 is accepted.
- Full frame: 144 pulses (sum = index) with wr_ready=1. Expect:
  - 6 plane_rdy pulses;
  - last write addr 143, data 16'h008F;
  - done=1 and busy=0 after the last write;
  - a further sum_valid produces no write and leaves overflow=0.
- Backpressure: wr_ready=0 while 4 sums (10,11,12,13) are pushed, then a 5th (14). Expect:
  - wr_en held with wr_addr=0, wr_data=10 stable;
  - 14 dropped, overflow=1;
  - after wr_ready=1, writes of 10,11,12,13 at addrs 0-3.
- Simultaneous: FIFO full, wr_ready=1, sum_valid=1 in the same cycle -> push accepted, overflow stays 0, count stays 4.
- ReLU: push 16'hFFFB then 16'h002A. Expect wr_data 16'h0000 then 16'h002A with ACC_WB_RELU_EN; 16'hFFFB then 16'h002A without it.
- Reset/start mid-frame: assert rst after 10 writes -> all outputs 0 immediately. Then start + 1 sum -> write at addr 0. Repeat using start alone mid-frame -> same result, with overflow and done cleared.

Source files
------------

// File: rtl/acc_wb.sv
// Convolution accumulator write-back: buffers finished sums in a FIFO and writes them
// to the output feature-map memory at linear addresses. Define ACC_WB_RELU_EN for ReLU at push.
module acc_wb #(
  parameter int PLANE_PIX  = 24,
  parameter int NUM_PLANES = 6,
  parameter int ADDR_W     = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [15:0]       sum,
  input  logic              sum_valid,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [15:0]       wr_data,
  input  logic              wr_ready,
  output logic              plane_rdy,
  output logic              done,
  output logic              busy,
  output logic              overflow
);

  localparam int PIX_W = (PLANE_PIX > 1) ? $clog2(PLANE_PIX) : 1;
  localparam int PL_W  = (NUM_PLANES > 1) ? $clog2(NUM_PLANES) : 1;
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t             r_state, w_state_nxt;
  logic [15:0]        r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]   r_wr_ptr, r_rd_ptr;
  logic [CNT_W-1:0]   r_count, w_count_nxt;
  logic [PIX_W-1:0]   r_pix;
  logic [PL_W-1:0]    r_plane;
  logic [ADDR_W-1:0]  r_base;
  logic               r_wr_en, r_plane_rdy, r_overflow;
  logic               w_pop, w_push, w_drop, w_pix_last, w_plane_last, w_last, w_wr_en_nxt;
  logic [15:0]        w_push_data;

`ifdef ACC_WB_RELU_EN
  assign w_push_data = sum[15] ? '0 : sum;
`else
  assign w_push_data = sum;
`endif

  always_comb begin
    w_pop        = r_wr_en && wr_ready && !start;
    w_pix_last   = (r_pix == PIX_W'(PLANE_PIX - 1));
    w_plane_last = (r_plane == PL_W'(NUM_PLANES - 1));
    w_last       = w_pop && w_pix_last && w_plane_last;
    // A pop in the same cycle frees a slot, so a full FIFO can still accept.
    w_push       = (r_state == S_RUN) && !start && sum_valid &&
                   ((r_count < CNT_W'(FIFO_DEPTH)) || w_pop);
    w_drop       = (r_state == S_RUN) && !start && sum_valid && !w_push;
    w_count_nxt  = r_count;
    if (start) begin
      w_count_nxt = '0;
    end else if (w_push && !w_pop) begin
      w_count_nxt = r_count + CNT_W'(1);
    end else if (w_pop && !w_push) begin
      w_count_nxt = r_count - CNT_W'(1);
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    if (start) begin
      w_state_nxt = S_RUN;
    end else if (r_state == S_RUN && w_last) begin
      w_state_nxt = S_DONE;
    end
    w_wr_en_nxt = (w_state_nxt == S_RUN) && (w_count_nxt != '0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
        r_mem[i] <= '0;
      end
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_wr_en     <= 1'b0;
      r_plane_rdy <= 1'b0;
      r_overflow  <= 1'b0;
    end else begin
      r_count     <= w_count_nxt;
      r_wr_en     <= w_wr_en_nxt;
      r_plane_rdy <= w_pop && w_pix_last;
      if (start) begin
        r_wr_ptr   <= '0;
        r_rd_ptr   <= '0;
        r_overflow <= 1'b0;
      end else begin
        if (w_push) begin
          r_mem[r_wr_ptr] <= w_push_data;
          r_wr_ptr        <= r_wr_ptr + PTR_W'(1);
        end
        if (w_pop) begin
          r_rd_ptr <= r_rd_ptr + PTR_W'(1);
        end
        if (w_drop) begin
          r_overflow <= 1'b1;
        end
      end
    end
  end

  // Address is base + pix; the base advances by PLANE_PIX per plane instead of multiplying.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pix   <= '0;
      r_plane <= '0;
      r_base  <= '0;
    end else if (start) begin
      r_pix   <= '0;
      r_plane <= '0;
      r_base  <= '0;
    end else if (w_pop) begin
      if (w_pix_last) begin
        r_pix <= '0;
        if (w_plane_last) begin
          r_plane <= '0;
          r_base  <= '0;
        end else begin
          r_plane <= r_plane + PL_W'(1);
          r_base  <= r_base + ADDR_W'(PLANE_PIX);
        end
      end else begin
        r_pix <= r_pix + PIX_W'(1);
      end
    end
  end

  assign wr_en     = r_wr_en;
  assign wr_addr   = r_base + ADDR_W'(r_pix);
  assign wr_data   = r_mem[r_rd_ptr];
  assign plane_rdy = r_plane_rdy;
  assign overflow  = r_overflow;
  assign done      = (r_state == S_DONE);
  assign busy      = (r_state == S_RUN);

endmodule

// File: tb/tb_acc_wb.sv
// Self-checking bench for acc_wb: queue-based reference model compared every cycle,
// plus directed scenario checks.
module tb_acc_wb;

  localparam int PIX   = 24;
  localparam int TOTAL = 144;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [15:0] sum = '0;
  logic        sum_valid = 1'b0;
  logic        wr_ready = 1'b0;
  logic        wr_en, plane_rdy, done, busy, overflow;
  logic [7:0]  wr_addr;
  logic [15:0] wr_data;

  acc_wb #(.PLANE_PIX(24), .NUM_PLANES(6), .ADDR_W(8), .FIFO_DEPTH(4)) dut (
    .clk(clk), .rst(rst), .start(start), .sum(sum), .sum_valid(sum_valid),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ready(wr_ready),
    .plane_rdy(plane_rdy), .done(done), .busy(busy), .overflow(overflow)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model: 0 idle, 1 run, 2 done
  logic [15:0] mq[$];
  int          m_state = 0;
  int          m_written = 0;
  bit          m_ovf = 0, m_wr_en = 0, m_prdy = 0;
  int          n_prdy = 0;
  int          obs_addr[$];
  int          obs_data[$];

  function automatic logic [15:0] relu(input logic [15:0] v);
`ifdef ACC_WB_RELU_EN
    return v[15] ? 16'h0000 : v;
`else
    return v;
`endif
  endfunction

  task automatic model_reset();
    mq.delete();
    m_state = 0; m_written = 0; m_ovf = 0; m_wr_en = 0; m_prdy = 0;
  endtask

  // One clock: drive inputs, advance the model, compare all outputs against it.
  task automatic step(input bit st, input bit sv, input logic [15:0] s, input bit rdy);
    bit pop, run_before;
    int sz;
    @(negedge clk);
    start = st; sum_valid = sv; sum = s; wr_ready = rdy;
    if (wr_en && rdy && !st) begin
      obs_addr.push_back(int'(wr_addr));
      obs_data.push_back(int'(wr_data));
    end
    @(posedge clk);
    pop = m_wr_en && rdy;
    run_before = (m_state == 1);
    sz = mq.size();
    m_prdy = 0;
    if (st) begin
      mq.delete(); m_written = 0; m_ovf = 0; m_state = 1;
    end else begin
      if (pop) begin
        void'(mq.pop_front());
        m_written++;
        if (m_written % PIX == 0) m_prdy = 1;
        if (m_written == TOTAL) m_state = 2;
      end
      if (run_before && sv) begin
        if (sz < DEPTH || pop) mq.push_back(relu(s));
        else m_ovf = 1;
      end
    end
    m_wr_en = (m_state == 1) && (mq.size() > 0);
    #1;
    if (plane_rdy) n_prdy++;
    checks++;
    if (wr_en !== m_wr_en) begin errors++; $display("FAIL wr_en: got %b exp %b at %0t", wr_en, m_wr_en, $time); end
    if (m_wr_en) begin
      checks++;
      if (wr_addr !== 8'(m_written % TOTAL)) begin
        errors++; $display("FAIL wr_addr: got %0d exp %0d at %0t", wr_addr, m_written % TOTAL, $time);
      end
      checks++;
      if (wr_data !== mq[0]) begin
        errors++; $display("FAIL wr_data: got %h exp %h at %0t", wr_data, mq[0], $time);
      end
    end
    checks++;
    if (plane_rdy !== m_prdy) begin errors++; $display("FAIL plane_rdy: got %b exp %b at %0t", plane_rdy, m_prdy, $time); end
    checks++;
    if (done !== (m_state == 2)) begin errors++; $display("FAIL done: got %b exp %b at %0t", done, m_state == 2, $time); end
    checks++;
    if (busy !== (m_state == 1)) begin errors++; $display("FAIL busy: got %b exp %b at %0t", busy, m_state == 1, $time); end
    checks++;
    if (overflow !== m_ovf) begin errors++; $display("FAIL overflow: got %b exp %b at %0t", overflow, m_ovf, $time); end
  endtask

  task automatic clear_obs();
    obs_addr.delete(); obs_data.delete(); n_prdy = 0;
  endtask

  task automatic drain();
    for (int i = 0; i < 12 && m_wr_en; i++) step(0, 0, 16'h0, 1);
  endtask

  task automatic test_reset();
    @(negedge clk);
    #2 rst = 1'b1;
    model_reset();
    #1;
    checks++;
    if ({wr_en, wr_addr, wr_data, plane_rdy, done, busy, overflow} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got en=%b addr=%0d data=%h prdy=%b done=%b busy=%b ovf=%b exp all 0",
               wr_en, wr_addr, wr_data, plane_rdy, done, busy, overflow);
    end
    @(negedge clk);
    rst = 1'b0;
    step(0, 1, 16'h5555, 1);  // ignored in IDLE
  endtask

  task automatic test_basic();
    step(1, 0, 16'h0, 1);
    clear_obs();
    for (int i = 0; i < PIX; i++) step(0, 1, 16'h0003, 1);
    for (int i = 0; i < 3; i++) step(0, 0, 16'h0, 1);
    checks++;
    if (n_prdy !== 1) begin errors++; $display("FAIL basic_prdy_count: got %0d exp 1", n_prdy); end
    checks++;
    if (obs_addr.size() !== PIX || obs_addr[PIX-1] !== PIX-1) begin
      errors++; $display("FAIL basic_writes: got n=%0d exp n=%0d last addr 23", obs_addr.size(), PIX);
    end
  endtask

  task automatic test_full_frame();
    step(1, 0, 16'h0, 1);
    clear_obs();
    for (int i = 0; i < TOTAL; i++) step(0, 1, 16'(i), 1);
    for (int i = 0; i < 3; i++) step(0, 0, 16'h0, 1);
    checks++;
    if (n_prdy !== 6) begin errors++; $display("FAIL frame_prdy_count: got %0d exp 6", n_prdy); end
    checks++;
    if (obs_addr.size() !== TOTAL || obs_addr[TOTAL-1] !== 143 || obs_data[TOTAL-1] !== 16'h008F) begin
      errors++; $display("FAIL frame_last_write: got n=%0d exp n=144 addr 143 data 008f", obs_addr.size());
    end
    checks++;
    if (done !== 1'b1 || busy !== 1'b0) begin
      errors++; $display("FAIL frame_done: got done=%b busy=%b exp done=1 busy=0", done, busy);
    end
    step(0, 1, 16'h1234, 1);
    step(0, 0, 16'h0, 1);
    checks++;
    if (wr_en !== 1'b0 || overflow !== 1'b0) begin
      errors++; $display("FAIL frame_post_done: got wr_en=%b ovf=%b exp 0 0", wr_en, overflow);
    end
  endtask

  task automatic test_backpressure();
    step(1, 0, 16'h0, 0);
    checks++;
    if (done !== 1'b0) begin errors++; $display("FAIL bp_done_cleared: got %b exp 0", done); end
    clear_obs();
    for (int i = 10; i <= 13; i++) step(0, 1, 16'(i), 0);
    step(0, 1, 16'd14, 0);
    step(0, 0, 16'h0, 0);
    checks++;
    if (overflow !== 1'b1 || wr_addr !== 8'd0 || wr_data !== 16'd10) begin
      errors++; $display("FAIL bp_hold: got ovf=%b addr=%0d data=%0d exp 1 0 10", overflow, wr_addr, wr_data);
    end
    drain();
    checks++;
    if (obs_addr.size() !== 4) begin
      errors++; $display("FAIL bp_count: got %0d exp 4", obs_addr.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (obs_addr[i] !== i || obs_data[i] !== 10 + i) begin
          errors++; $display("FAIL bp_order: got addr=%0d data=%0d exp %0d %0d", obs_addr[i], obs_data[i], i, 10 + i);
        end
      end
    end
  endtask

  task automatic test_simultaneous();
    step(1, 0, 16'h0, 0);
    clear_obs();
    for (int i = 0; i < 4; i++) step(0, 1, 16'(20 + i), 0);
    step(0, 1, 16'd24, 1);
    checks++;
    if (overflow !== 1'b0) begin errors++; $display("FAIL simul_ovf: got %b exp 0", overflow); end
    drain();
    checks++;
    if (obs_data.size() !== 5 || obs_data[4] !== 24) begin
      errors++; $display("FAIL simul_writes: got n=%0d exp 5 ending in 24", obs_data.size());
    end
  endtask

  task automatic test_relu();
    logic [15:0] exp0;
`ifdef ACC_WB_RELU_EN
    exp0 = 16'h0000;
`else
    exp0 = 16'hFFFB;
`endif
    step(1, 0, 16'h0, 1);
    clear_obs();
    step(0, 1, 16'hFFFB, 1);
    step(0, 1, 16'h002A, 1);
    drain();
    checks++;
    if (obs_data.size() !== 2 || obs_data[0] !== int'(exp0) || obs_data[1] !== 32'h2A) begin
      errors++; $display("FAIL relu: got n=%0d exp data %h then 002a", obs_data.size(), exp0);
    end
  endtask

  task automatic test_midframe();
    step(1, 0, 16'h0, 1);
    for (int i = 0; i < 10; i++) step(0, 1, 16'(i + 1), 1);
    step(0, 0, 16'h0, 1);
    test_reset();
    step(1, 0, 16'h0, 1);
    clear_obs();
    step(0, 1, 16'h0007, 1);
    drain();
    checks++;
    if (obs_addr.size() !== 1 || obs_addr[0] !== 0) begin
      errors++; $display("FAIL reset_restart_addr: got n=%0d exp one write at 0", obs_addr.size());
    end
    for (int i = 0; i < 10; i++) step(0, 1, 16'(i + 1), 1);
    step(0, 0, 16'h0, 1);
    for (int i = 0; i < 6; i++) step(0, 1, 16'h0100, 0);
    checks++;
    if (overflow !== 1'b1) begin errors++; $display("FAIL start_pre_ovf: got %b exp 1", overflow); end
    step(1, 1, 16'h0999, 1);
    checks++;
    if (overflow !== 1'b0 || wr_en !== 1'b0) begin
      errors++; $display("FAIL start_flush: got ovf=%b wr_en=%b exp 0 0", overflow, wr_en);
    end
    clear_obs();
    step(0, 1, 16'h0008, 1);
    drain();
    checks++;
    if (obs_addr.size() !== 1 || obs_addr[0] !== 0 || obs_data[0] !== 8) begin
      errors++; $display("FAIL start_restart_addr: got n=%0d exp one write of 8 at 0", obs_addr.size());
    end
  endtask

  task automatic test_random();
    step(1, 0, 16'h0, 1);
    for (int i = 0; i < 600; i++) begin
      step(($urandom % 150) == 0, $urandom % 2, 16'($urandom), $urandom_range(0, 3) != 0);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_full_frame();
    test_backpressure();
    test_simultaneous();
    test_relu();
    test_midframe();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
